// File: rtl/pwm_seq_ctrl.sv
// PWM configuration sequencer: a small command queue whose head is applied
// to the PWM generator only at period boundaries, held for repeat+1 periods.
module pwm_seq_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_hold_last,
  input  logic                       i_cfg_valid,
  output logic                       o_cfg_ready,
  input  logic [15:0]                i_cfg_period,
  input  logic [15:0]                i_cfg_compare1,
  input  logic [15:0]                i_cfg_compare2,
  input  logic [7:0]                 i_cfg_functions,
  input  logic [7:0]                 i_cfg_repeat,
  input  logic [15:0]                i_count_val,
  output logic                       o_pwm_en,
  output logic                       o_cnt_clr,
  output logic [15:0]                o_period,
  output logic [15:0]                o_compare1,
  output logic [15:0]                o_compare2,
  output logic [7:0]                 o_functions,
  output logic                       o_busy,
  output logic                       o_underrun,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] cmp1;
    logic [15:0] cmp2;
    logic [7:0]  func;
    logic [7:0]  rep;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  state_t        r_state;
  logic [7:0]    r_rep_cnt;
  logic [7:0]    r_act_rep;
  logic [15:0]   r_period;
  logic [15:0]   r_cmp1;
  logic [15:0]   r_cmp2;
  logic [7:0]    r_func;
  logic          r_pwm_en;
  logic          r_cnt_clr;
  logic          r_busy;
  logic          r_underrun;

  cmd_t          w_in;
  cmd_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_wrap;
  logic          w_push;
  logic          w_adv;
  logic          w_pop;

  assign w_in = {i_cfg_period, i_cfg_compare1, i_cfg_compare2,
                 i_cfg_functions, i_cfg_repeat};
  assign w_head  = r_mem[r_rd_ptr];
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_wrap  = (r_state == S_RUN) && (i_count_val == r_period);
  assign w_push  = i_cfg_valid & ~w_full & ~i_abort;
  assign w_adv   = w_wrap & (r_rep_cnt == 8'd0) & ~w_empty;
  assign w_pop   = ~i_abort & ((r_state == S_LOAD) | w_adv);

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rep_cnt  <= '0;
      r_act_rep  <= '0;
      r_period   <= '0;
      r_cmp1     <= '0;
      r_cmp2     <= '0;
      r_func     <= '0;
      r_pwm_en   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else if (i_abort) begin
      r_state   <= S_IDLE;
      r_pwm_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start && !w_empty) begin
            r_state    <= S_LOAD;
            r_underrun <= 1'b0;
            r_cnt_clr  <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          r_period  <= w_head.period;
          r_cmp1    <= w_head.cmp1;
          r_cmp2    <= w_head.cmp2;
          r_func    <= w_head.func;
          r_rep_cnt <= w_head.rep;
          r_act_rep <= w_head.rep;
          r_cnt_clr <= 1'b0;
          r_pwm_en  <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (w_wrap) begin
            if (r_rep_cnt != 8'd0) begin
              r_rep_cnt <= r_rep_cnt - 8'd1;
            end else if (!w_empty) begin
              // Counter wraps on its own here; no clear needed.
              r_period  <= w_head.period;
              r_cmp1    <= w_head.cmp1;
              r_cmp2    <= w_head.cmp2;
              r_func    <= w_head.func;
              r_rep_cnt <= w_head.rep;
              r_act_rep <= w_head.rep;
            end else if (i_hold_last) begin
              r_underrun <= 1'b1;
              r_rep_cnt  <= r_act_rep;
            end else begin
              r_underrun <= 1'b1;
              r_state    <= S_IDLE;
              r_pwm_en   <= 1'b0;
              r_busy     <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_pwm_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_ready = ~w_full;
  assign o_level     = r_level;
  assign o_pwm_en    = r_pwm_en;
  assign o_cnt_clr   = r_cnt_clr;
  assign o_period    = r_period;
  assign o_compare1  = r_cmp1;
  assign o_compare2  = r_cmp2;
  assign o_functions = r_func;
  assign o_busy      = r_busy;
  assign o_underrun  = r_underrun;

endmodule
